// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Loads IM/DM from a valid/ready stream, releases the core, times
//            the run with a watchdog and flags completion.
// Revision : 1.0
// ============================================================================
module cpu_run_ctrl #(
  parameter int INSTR_W  = 16,
  parameter int DATA_W   = 8,
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 256,
  parameter int TIMEOUT  = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  status,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [INSTR_W-1:0]          load_data,
  input  logic                        load_last,
  output logic                        im_we,
  output logic [$clog2(IM_DEPTH)-1:0] im_addr,
  output logic [INSTR_W-1:0]          im_wdata,
  output logic                        dm_we,
  output logic [$clog2(DM_DEPTH)-1:0] dm_addr,
  output logic [DATA_W-1:0]           dm_wdata,
  output logic                        core_rst_n,
  input  logic                        core_halt,
  output logic                        end_process,
  output logic                        timeout,
  output logic                        load_err,
  output logic [31:0]                 cycle_count
);

  localparam int c_im_aw = $clog2(IM_DEPTH);
  localparam int c_dm_aw = $clog2(DM_DEPTH);
  localparam logic [c_im_aw-1:0] c_im_last = c_im_aw'(IM_DEPTH - 1);
  localparam logic [c_dm_aw-1:0] c_dm_last = c_dm_aw'(DM_DEPTH - 1);
  localparam logic [31:0] c_timeout = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IM = 3'd1,
    S_LOAD_DM = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_im_aw-1:0] r_im_cnt;
  logic [c_dm_aw-1:0] r_dm_cnt;
  logic [31:0]        w_cnt_next;
  logic               w_im_full;
  logic               w_dm_full;

  assign w_cnt_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
  assign w_im_full  = (r_im_cnt == c_im_last);
  assign w_dm_full  = (r_dm_cnt == c_dm_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_im_cnt    <= '0;
      r_dm_cnt    <= '0;
      load_ready  <= 1'b0;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      core_rst_n  <= 1'b0;
      end_process <= 1'b0;
      timeout     <= 1'b0;
      load_err    <= 1'b0;
      cycle_count <= '0;
    end else begin
      im_we <= 1'b0;
      dm_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          case (status)
            2'b01: begin
              r_state    <= S_LOAD_IM;
              r_im_cnt   <= '0;
              load_err   <= 1'b0;
              load_ready <= 1'b1;
            end
            2'b10: begin
              r_state    <= S_LOAD_DM;
              r_dm_cnt   <= '0;
              load_err   <= 1'b0;
              load_ready <= 1'b1;
            end
            2'b11: begin
              r_state     <= S_RUN;
              cycle_count <= '0;
              end_process <= 1'b0;
              timeout     <= 1'b0;
              core_rst_n  <= 1'b1;
            end
            default: ;
          endcase
        end
        // load_ready is high throughout a LOAD state, so load_valid alone means accept
        S_LOAD_IM: begin
          if (load_valid) begin
            im_we    <= 1'b1;
            im_addr  <= r_im_cnt;
            im_wdata <= load_data;
            if (!w_im_full) r_im_cnt <= r_im_cnt + 1'b1;
            if (load_last || w_im_full) begin
              r_state    <= S_IDLE;
              load_ready <= 1'b0;
              load_err   <= ~load_last;
            end
          end
        end
        S_LOAD_DM: begin
          if (load_valid) begin
            dm_we    <= 1'b1;
            dm_addr  <= r_dm_cnt;
            dm_wdata <= load_data[DATA_W-1:0];
            if (!w_dm_full) r_dm_cnt <= r_dm_cnt + 1'b1;
            if (load_last || w_dm_full) begin
              r_state    <= S_IDLE;
              load_ready <= 1'b0;
              load_err   <= ~load_last;
            end
          end
        end
        // Every RUN cycle counts, including the one on which the run ends
        S_RUN: begin
          cycle_count <= w_cnt_next;
          if (core_halt) begin
            r_state     <= S_DONE;
            end_process <= 1'b1;
            core_rst_n  <= 1'b0;
          end else if ((TIMEOUT != 0) && (w_cnt_next == c_timeout)) begin
            r_state     <= S_DONE;
            end_process <= 1'b1;
            timeout     <= 1'b1;
            core_rst_n  <= 1'b0;
          end
        end
        S_DONE: begin
          if (status == 2'b00) begin
            r_state     <= S_IDLE;
            end_process <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Directed self-checking bench for cpu_run_ctrl (two configurations).
// Revision : 1.0
// ============================================================================
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  status;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        core_halt;

  // Instance a: small DM, default watchdog
  logic        a_load_ready, a_im_we, a_dm_we, a_core_rst_n, a_end_process, a_timeout, a_load_err;
  logic [7:0]  a_im_addr;
  logic [15:0] a_im_wdata;
  logic [1:0]  a_dm_addr;
  logic [7:0]  a_dm_wdata;
  logic [31:0] a_cycle_count;

  // Instance b: TIMEOUT = 50
  logic        b_load_ready, b_im_we, b_dm_we, b_core_rst_n, b_end_process, b_timeout, b_load_err;
  logic [7:0]  b_im_addr;
  logic [15:0] b_im_wdata;
  logic [7:0]  b_dm_addr;
  logic [7:0]  b_dm_wdata;
  logic [31:0] b_cycle_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.INSTR_W(16), .DATA_W(8), .IM_DEPTH(256), .DM_DEPTH(4), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst_n(rst_n), .status(status), .load_valid(load_valid),
    .load_ready(a_load_ready), .load_data(load_data), .load_last(load_last),
    .im_we(a_im_we), .im_addr(a_im_addr), .im_wdata(a_im_wdata),
    .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .core_rst_n(a_core_rst_n), .core_halt(core_halt), .end_process(a_end_process),
    .timeout(a_timeout), .load_err(a_load_err), .cycle_count(a_cycle_count)
  );

  cpu_run_ctrl #(.INSTR_W(16), .DATA_W(8), .IM_DEPTH(256), .DM_DEPTH(256), .TIMEOUT(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .status(status), .load_valid(load_valid),
    .load_ready(b_load_ready), .load_data(load_data), .load_last(load_last),
    .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
    .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .core_rst_n(b_core_rst_n), .core_halt(core_halt), .end_process(b_end_process),
    .timeout(b_timeout), .load_err(b_load_err), .cycle_count(b_cycle_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] dm_words [3];
    logic [7:0]  dm_bytes [3];
    dm_words = '{16'h01AB, 16'h02CD, 16'h03EF};
    dm_bytes = '{8'hAB, 8'hCD, 8'hEF};

    rst_n = 1'b0; status = 2'b00; load_valid = 1'b0; load_data = '0; load_last = 1'b0; core_halt = 1'b0;
    #2;
    chk("rst_ready", {31'd0, a_load_ready}, 32'd0);
    chk("rst_core_rst_n", {31'd0, a_core_rst_n}, 32'd0);
    chk("rst_we", {30'd0, a_im_we, a_dm_we}, 32'd0);
    chk("rst_flags", {29'd0, a_end_process, a_timeout, a_load_err}, 32'd0);
    chk("rst_cycle_count", a_cycle_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // IM load: four words, last on the fourth
    status = 2'b01;
    tick();
    status = 2'b00;
    chk("im_ready_on_entry", {31'd0, a_load_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 16'h1111 * 16'(i + 1);
      load_last  = (i == 3);
      tick();
      chk("im_we", {31'd0, a_im_we}, 32'd1);
      chk("im_addr", {24'd0, a_im_addr}, 32'(i));
      chk("im_wdata", {16'd0, a_im_wdata}, 32'h1111 * 32'(i + 1));
      chk("im_no_dm_we", {31'd0, a_dm_we}, 32'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("im_ready_after_last", {31'd0, a_load_ready}, 32'd0);
    tick();
    chk("im_we_idle", {31'd0, a_im_we}, 32'd0);

    // DM load with a gap before every word
    status = 2'b10;
    tick();
    status = 2'b00;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b0;
      tick();
      chk("dm_gap_no_we", {31'd0, a_dm_we}, 32'd0);
      load_valid = 1'b1;
      load_data  = dm_words[i];
      load_last  = (i == 2);
      tick();
      chk("dm_we", {31'd0, a_dm_we}, 32'd1);
      chk("dm_addr", {30'd0, a_dm_addr}, 32'(i));
      chk("dm_wdata", {24'd0, a_dm_wdata}, {24'd0, dm_bytes[i]});
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    chk("dm_ready_after_last", {31'd0, a_load_ready}, 32'd0);
    chk("dm_we_idle", {31'd0, a_dm_we}, 32'd0);

    // DM overflow on the 4-word instance
    status = 2'b10;
    tick();
    status = 2'b00;
    load_valid = 1'b1;
    load_last  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_data = 16'h0010 + 16'(i);
      tick();
      if (i < 4) begin
        chk("ovf_we", {31'd0, a_dm_we}, 32'd1);
        chk("ovf_addr", {30'd0, a_dm_addr}, 32'(i));
      end else begin
        chk("ovf_no_we", {31'd0, a_dm_we}, 32'd0);
        chk("ovf_no_wrap", {30'd0, a_dm_addr}, 32'd3);
      end
      if (i == 3) begin
        chk("ovf_load_err", {31'd0, a_load_err}, 32'd1);
        chk("ovf_ready_low", {31'd0, a_load_ready}, 32'd0);
      end
    end
    // close instance b's still-open DM stream
    load_last = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("ovf_err_sticky", {31'd0, a_load_err}, 32'd1);
    chk("b_no_load_err", {31'd0, b_load_err}, 32'd0);

    // Run: a halts at 100 cycles, b hits its watchdog at 50
    status = 2'b11;
    tick();
    chk("run_core_rst_n", {31'd0, a_core_rst_n}, 32'd1);
    chk("run_count_start", a_cycle_count, 32'd0);
    chk("run_ep_low", {31'd0, a_end_process}, 32'd0);
    for (int i = 1; i <= 100; i++) begin
      core_halt = (i == 100);
      tick();
      if (i == 49) chk("wd_before", {31'd0, b_end_process}, 32'd0);
      if (i == 50) begin
        chk("wd_ep", {31'd0, b_end_process}, 32'd1);
        chk("wd_timeout", {31'd0, b_timeout}, 32'd1);
        chk("wd_count", b_cycle_count, 32'd50);
        chk("wd_core_rst_n", {31'd0, b_core_rst_n}, 32'd0);
        chk("a_still_running", {31'd0, a_end_process}, 32'd0);
        chk("a_count_50", a_cycle_count, 32'd50);
      end
    end
    core_halt = 1'b0;
    chk("halt_ep", {31'd0, a_end_process}, 32'd1);
    chk("halt_timeout", {31'd0, a_timeout}, 32'd0);
    chk("halt_count", a_cycle_count, 32'd100);
    chk("halt_core_rst_n", {31'd0, a_core_rst_n}, 32'd0);
    repeat (3) tick();
    chk("done_ep_hold", {31'd0, a_end_process}, 32'd1);
    chk("done_count_frozen", a_cycle_count, 32'd100);
    chk("wd_count_frozen", b_cycle_count, 32'd50);
    status = 2'b10;
    tick();
    tick();
    chk("done_ignores_10", {31'd0, a_end_process}, 32'd1);
    chk("done_no_ready", {31'd0, a_load_ready}, 32'd0);
    status = 2'b00;
    tick();
    chk("done_exit_ep", {31'd0, a_end_process}, 32'd0);

    // Halt and watchdog on the same cycle: halt wins
    status = 2'b11;
    tick();
    chk("rerun_timeout_clear", {31'd0, b_timeout}, 32'd0);
    for (int i = 1; i <= 50; i++) begin
      core_halt = (i == 50);
      tick();
    end
    core_halt = 1'b0;
    chk("tie_ep", {31'd0, b_end_process}, 32'd1);
    chk("tie_timeout", {31'd0, b_timeout}, 32'd0);
    chk("tie_count", b_cycle_count, 32'd50);
    status = 2'b00;
    tick();

    // Reset in the middle of an IM load
    status = 2'b01;
    tick();
    status = 2'b00;
    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_data = 16'hA000 + 16'(i);
      tick();
    end
    load_valid = 1'b0;
    chk("mid_we_before", {31'd0, a_im_we}, 32'd1);
    chk("mid_addr_before", {24'd0, a_im_addr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, a_im_we}, 32'd0);
    chk("mid_rst_addr", {24'd0, a_im_addr}, 32'd0);
    chk("mid_rst_ready", {31'd0, a_load_ready}, 32'd0);
    chk("mid_rst_load_err", {31'd0, a_load_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    status = 2'b01;
    tick();
    status = 2'b00;
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("reload_we", {31'd0, a_im_we}, 32'd1);
    chk("reload_addr", {24'd0, a_im_addr}, 32'd0);
    chk("reload_data", {16'd0, a_im_wdata}, 32'h0000BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
